// File: rtl/fixed_point_accum.sv
// fixed_point_accum: accumulates signed fixed-point beats into a per-frame sum.
// A frame ends on in_last or after FRAME_LEN beats; the result is then held
// until the downstream handshake completes.
// Optional feature macro: FXP_ACCUM_SAT_EN (saturating adds with a sticky
// out_sat flag). Without it, adds wrap modulo 2^ACC_W and out_sat is 0.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both 1. The valid side holds its payload until
// that edge. in_ready depends only on state (never on in_valid); out_valid
// depends only on state (never on out_ready).
module fixed_point_accum #(
  parameter int DATA_W    = 8,
  parameter int FRAC_W    = 4,
  parameter int ACC_W     = 10,
  parameter int FRAME_LEN = 8,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               sat, sat_next;

  // Input and output share the binary point, so the sample is only
  // sign-extended to the accumulator width; no shift is applied.
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               sum_clamped;
  logic [CNT_W-1:0]   count_inc;
  logic               beat;

  assign in_ext = {{(ACC_W - DATA_W + 1){in_data[DATA_W-1]}}, in_data[DATA_W-2:0]};

`ifdef FXP_ACCUM_SAT_EN
  logic [ACC_W:0] sum_wide;

  // Saturating add: one guard bit detects overflow; clamp toward the sign of
  // the true result so accumulation continues from the clamped value.
  always_comb begin
    sum_wide    = {acc[ACC_W-1], acc} + {in_ext[ACC_W-1], in_ext};
    acc_sum     = sum_wide[ACC_W-1:0];
    sum_clamped = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_clamped = 1'b1;
      acc_sum     = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  // Wrapping add: the carry out of the top bit is simply dropped.
  always_comb begin
    acc_sum     = acc + in_ext;
    sum_clamped = 1'b0;
  end
`endif

  assign beat      = in_valid & in_ready;
  assign count_inc = count + CNT_W'(1);

  // State register with asynchronous active-low reset; reset discards any
  // partial or pending frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      sat   <= sat_next;
    end
  end

  // Next-state logic: load on the first beat, add on later beats, close the
  // frame on in_last or when the beat count reaches FRAME_LEN.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    sat_next   = sat;
    unique case (state)
      IDLE: begin
        if (beat) begin
          acc_next   = in_ext;
          count_next = CNT_W'(1);
          sat_next   = 1'b0;
          if (in_last || (CNT_W'(1) == CNT_W'(FRAME_LEN))) state_next = OUTPUT;
          else                                              state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_next   = acc_sum;
          count_next = count_inc;
          sat_next   = sat | sum_clamped;
          if (in_last || (count_inc == CNT_W'(FRAME_LEN))) state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: results are visible only while out_valid is high and are
  // forced to zero otherwise.
  always_comb begin
    in_ready  = (state != OUTPUT);
    out_valid = (state == OUTPUT);
    out_data  = out_valid ? acc : '0;
    out_count = out_valid ? count : '0;
`ifdef FXP_ACCUM_SAT_EN
    out_sat   = out_valid ? sat : 1'b0;
`else
    out_sat   = 1'b0;
`endif
    dbg_state = state;
  end

endmodule

// File: tb/tb_fixed_point_accum.sv
// tb_fixed_point_accum: directed bench for fixed_point_accum with default
// parameters (Q4.4 input, 10-bit sum, FRAME_LEN 8). Expected frame results
// are hand-computed and queued before each frame is driven.
module tb_fixed_point_accum;

  localparam int DATA_W    = 8;
  localparam int FRAC_W    = 4;
  localparam int ACC_W     = 10;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int EXP_W     = 1 + CNT_W + ACC_W;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  // expected frame results packed as {sat, count, data}
  logic [EXP_W-1:0] exp_q[$];

  fixed_point_accum #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat), .dbg_state(dbg_state)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one beat; called 1 time unit after a rising edge, returns likewise.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic sat, input logic [CNT_W-1:0] cnt, input logic [ACC_W-1:0] d);
    exp_q.push_back({sat, cnt, d});
  endtask

  // Compare the held result against the queue head, then complete the handshake.
  task automatic take_frame(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".valid"}, 32'(out_valid), 32'(1));
    check({tag, ".data"},  32'(out_data),  32'(e[ACC_W-1:0]));
    check({tag, ".count"}, 32'(out_count), 32'(e[ACC_W +: CNT_W]));
    check({tag, ".sat"},   32'(out_sat),   32'(e[EXP_W-1]));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_after"}, 32'(out_valid), 32'(0));
    check({tag, ".data_after"},  32'(out_data),  32'(0));
    check({tag, ".ready_after"}, 32'(in_ready),  32'(1));
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // reset state
    check("rst.valid", 32'(out_valid), 32'(0));
    check("rst.ready", 32'(in_ready),  32'(1));
    check("rst.data",  32'(out_data),  32'(0));
    check("rst.count", 32'(out_count), 32'(0));
    check("rst.state", 32'(dbg_state), 32'(0));
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 4 x 1.5 = 6.0; valid one cycle after the 4th beat
    push_exp(1'b0, 4'd4, 10'h060);
    send_beat(8'h18, 1'b0);
    send_beat(8'h18, 1'b0);
    send_beat(8'h18, 1'b0);
    check("f1.pre_valid", 32'(out_valid), 32'(0));
    send_beat(8'h18, 1'b1);
    take_frame("f1");

    // -2.0 + 0.5 = -1.5
    push_exp(1'b0, 4'd2, 10'h3E8);
    send_beat(8'hE0, 1'b0);
    send_beat(8'h08, 1'b1);
    take_frame("f2");

    // eight 0x7F beats, closed by FRAME_LEN
`ifdef FXP_ACCUM_SAT_EN
    push_exp(1'b1, 4'd8, 10'h1FF);
`else
    push_exp(1'b0, 4'd8, 10'h3F8);
`endif
    for (int i = 0; i < 7; i++) send_beat(8'h7F, 1'b0);
    check("f3.pre_valid", 32'(out_valid), 32'(0));
    send_beat(8'h7F, 1'b0);
    take_frame("f3");

    // one-beat frame
    push_exp(1'b0, 4'd1, 10'h3F0);
    send_beat(8'hF0, 1'b1);
    take_frame("f4");

    // idle gap mid-frame: state held, no timeout; 0.5 + 1.5 = 2.0
    push_exp(1'b0, 4'd2, 10'h020);
    send_beat(8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("gap.state", 32'(dbg_state), 32'(1));
      check("gap.valid", 32'(out_valid), 32'(0));
      @(posedge clock);
      #1;
    end
    send_beat(8'h18, 1'b1);
    take_frame("f5");

    // backpressure in OUTPUT with in_valid held high: 2.0 + 2.0 = 4.0
    send_beat(8'h20, 1'b0);
    send_beat(8'h20, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h30;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall.in_ready", 32'(in_ready),  32'(0));
      check("stall.valid",    32'(out_valid), 32'(1));
      check("stall.data",     32'(out_data),  32'(10'h040));
      check("stall.count",    32'(out_count), 32'(2));
      @(posedge clock);
      #1;
    end
    // handshake edge: the waiting beat is not consumed here
    in_data   = 8'h10;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("stall.idle_state", 32'(dbg_state), 32'(0));
    check("stall.idle_valid", 32'(out_valid), 32'(0));
    // the held beat now starts a fresh one-beat frame
    push_exp(1'b0, 4'd1, 10'h010);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_frame("f6");

    // reset mid-frame discards the partial sum
    send_beat(8'h10, 1'b0);
    send_beat(8'h10, 1'b0);
    send_beat(8'h10, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_mid.valid", 32'(out_valid), 32'(0));
    check("rst_mid.state", 32'(dbg_state), 32'(0));
    check("rst_mid.ready", 32'(in_ready),  32'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;
    push_exp(1'b0, 4'd1, 10'h010);
    send_beat(8'h10, 1'b1);
    take_frame("f7");

    // reset while a result is pending drops it immediately
    send_beat(8'h10, 1'b1);
    check("rst_out.pre_valid", 32'(out_valid), 32'(1));
    reset = 1'b0;
    #1;
    check("rst_out.valid", 32'(out_valid), 32'(0));
    check("rst_out.data",  32'(out_data),  32'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_out.post_valid", 32'(out_valid), 32'(0));
    push_exp(1'b0, 4'd2, 10'h030);
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b1);
    take_frame("f8");

    check("sb.empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
